// File: rtl/ky32_demux4x32_buf_if.sv
// Channel bundle for the buffered 1-to-4 word demux: one producer-facing
// valid/ready input and four consumer-facing valid/ready outputs.
interface ky32_demux4x32_buf_if #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 32
);
    localparam int SEL_W = $clog2(NUM_LANES);

    logic                         in_valid;
    logic                         in_ready;
    logic [SEL_W-1:0]             in_sel;
    logic [VEC_W-1:0]             in_data;
    logic [NUM_LANES-1:0]         out_valid;
    logic [NUM_LANES-1:0]         out_ready;
    logic [NUM_LANES*VEC_W-1:0]   out_data;
    logic [NUM_LANES*2-1:0]       out_count;

    // Producer plus consumers side.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // Demux side.
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/ky32_demux4x32_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted word into one of four
// independent 2-entry FIFOs, each drained by its own valid/ready channel.
module ky32_demux4x32_buf_lane #(
    parameter int VEC_W = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic             pop,
    input  logic [VEC_W-1:0] wdata,
    output logic             valid,
    output logic             full,
    output logic [VEC_W-1:0] rdata,
    output logic [1:0]       count
);
    logic [1:0][VEC_W-1:0] mem;
    logic                  rptr, wptr;
    logic [1:0]            cnt;

    // Storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rptr <= 1'b0;
            wptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign full  = (cnt == 2'd2);
    assign rdata = mem[rptr];
    assign count = cnt;
endmodule

module ky32_demux4x32_buf #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 32
) (
    input  logic                       clk,
    input  logic                       clrn,
    ky32_demux4x32_buf_if.slave        bus
);
    logic [NUM_LANES-1:0]             push, pop, full, valid;
    logic [NUM_LANES-1:0][VEC_W-1:0]  rdata;
    logic [NUM_LANES-1:0][1:0]        cnt;

    // A full lane still accepts when its head is leaving this same cycle.
    assign bus.in_ready = ~full[bus.in_sel] | bus.out_ready[bus.in_sel];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        // in_valid gates first so an undriven in_sel cannot reach lane state.
        assign push[k] = bus.in_valid & bus.in_ready & (bus.in_sel == k);
        assign pop[k]  = valid[k] & bus.out_ready[k];

        ky32_demux4x32_buf_lane #(.VEC_W(VEC_W)) u_lane (
            .clk   (clk),
            .clrn  (clrn),
            .push  (push[k]),
            .pop   (pop[k]),
            .wdata (bus.in_data),
            .valid (valid[k]),
            .full  (full[k]),
            .rdata (rdata[k]),
            .count (cnt[k])
        );
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = rdata;
    assign bus.out_count = cnt;
endmodule

// File: tb/tb_ky32_demux4x32_buf.sv
// Directed bench for the buffered 1-to-4 word demux with hand-computed expectations.
module tb_ky32_demux4x32_buf;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ky32_demux4x32_buf_if bus ();

    ky32_demux4x32_buf dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] ir;
        clrn = 1'b0;
        bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'h0;
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 4'h0) begin
            errors++; $display("FAIL reset_valid got=%h exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_count !== 8'h00) begin
            errors++; $display("FAIL reset_count got=%h exp=00", bus.out_count);
        end
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1 ir[s] = bus.in_ready;
        end
        checks++;
        if (ir !== 4'hf) begin
            errors++; $display("FAIL reset_in_ready per-sel got=%b exp=1111", ir);
        end
        for (int i = 0; i < 4; i++) begin
            bus.in_sel = 2'($urandom_range(0, 3));
            bus.in_data = $urandom;
            tick();
        end
        checks++;
        if (bus.out_valid !== 4'h0 || bus.out_count !== 8'h00) begin
            errors++; $display("FAIL idle_no_change valid=%h count=%h exp 0/00", bus.out_valid, bus.out_count);
        end
    endtask

    task automatic test_routing();
        logic [31:0] w [4];
        w[0] = 32'hA0; w[1] = 32'hB1; w[2] = 32'hC2; w[3] = 32'hD3;
        bus.out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'(k); bus.in_data = w[k];
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_count !== 8'b01010101) begin
            errors++; $display("FAIL route_count got=%b exp=01010101", bus.out_count);
        end
        checks++;
        if (bus.out_valid !== 4'hf) begin
            errors++; $display("FAIL route_valid got=%h exp=f", bus.out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.out_data[32*k +: 32] !== w[k]) begin
                errors++; $display("FAIL route_data lane%0d got=%h exp=%h", k, bus.out_data[32*k +: 32], w[k]);
            end
        end
        bus.out_ready = 4'hf;
        tick();
        bus.out_ready = 4'h0;
        #1;
        checks++;
        if (bus.out_valid !== 4'h0 || bus.out_count !== 8'h00) begin
            errors++; $display("FAIL route_drain valid=%h count=%h exp 0/00", bus.out_valid, bus.out_count);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 4'h0;
        bus.in_valid = 1'b1; bus.in_sel = 2'd2;
        bus.in_data = 32'h1; tick();
        bus.in_data = 32'h2; tick();
        bus.in_data = 32'h3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_count[5:4] !== 2'd2) begin
            errors++; $display("FAIL bp_stall in_ready=%b count=%0d exp 0/2", bus.in_ready, bus.out_count[5:4]);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_count[5:4] !== 2'd2 || bus.out_data[95:64] !== 32'h1) begin
            errors++; $display("FAIL bp_hold in_ready=%b count=%0d head=%h exp 0/2/1",
                               bus.in_ready, bus.out_count[5:4], bus.out_data[95:64]);
        end
        bus.out_ready[2] = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_data[95:64] !== 32'h1) begin
            errors++; $display("FAIL bp_release in_ready=%b head=%h exp 1/1", bus.in_ready, bus.out_data[95:64]);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_data[95:64] !== 32'h2 || bus.out_count[5:4] !== 2'd2) begin
            errors++; $display("FAIL bp_order2 head=%h count=%0d exp 2/2", bus.out_data[95:64], bus.out_count[5:4]);
        end
        tick();
        checks++;
        if (bus.out_data[95:64] !== 32'h3 || bus.out_count[5:4] !== 2'd1) begin
            errors++; $display("FAIL bp_order3 head=%h count=%0d exp 3/1", bus.out_data[95:64], bus.out_count[5:4]);
        end
        tick();
        checks++;
        if (bus.out_valid[2] !== 1'b0) begin
            errors++; $display("FAIL bp_empty valid2=%b exp=0", bus.out_valid[2]);
        end
        bus.out_ready = 4'h0;
    endtask

    task automatic test_wraparound();
        int bad = 0;
        bus.out_ready = 4'b0010;
        bus.in_sel = 2'd1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(i);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL wrap_ready word%0d got=%b exp=1", i, bus.in_ready);
            end
            if (i > 0) begin
                checks++;
                if (bus.out_data[63:32] !== 32'(i - 1) || bus.out_count[3:2] !== 2'd1) begin
                    errors++; $display("FAIL wrap_out word%0d head=%h count=%0d exp %h/1",
                                       i, bus.out_data[63:32], bus.out_count[3:2], i - 1);
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_data[63:32] !== 32'd9 || bus.out_count[3:2] !== 2'd1) begin
            errors++; $display("FAIL wrap_last head=%h count=%0d exp 9/1", bus.out_data[63:32], bus.out_count[3:2]);
        end
        tick();
        checks++;
        if (bus.out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL wrap_empty valid1=%b exp=0", bus.out_valid[1]);
        end
        bus.out_ready = 4'h0;
    endtask

    task automatic test_cross_lane();
        bus.out_ready = 4'h0;
        bus.in_valid = 1'b1; bus.in_sel = 2'd3;
        bus.in_data = 32'h30; tick();
        bus.in_data = 32'h31; tick();
        bus.in_data = 32'h32;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL xl_ready_sel3 got=%b exp=0", bus.in_ready);
        end
        bus.in_sel = 2'd0; bus.in_data = 32'h40;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL xl_ready_sel0 got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_count !== 8'b10000001 || bus.out_data[31:0] !== 32'h40 || bus.out_data[127:96] !== 32'h30) begin
            errors++; $display("FAIL xl_state count=%b lane0=%h lane3=%h exp 10000001/40/30",
                               bus.out_count, bus.out_data[31:0], bus.out_data[127:96]);
        end
        bus.out_ready = 4'hf;
        tick(); tick();
        bus.out_ready = 4'h0;
        #1;
        checks++;
        if (bus.out_valid !== 4'h0) begin
            errors++; $display("FAIL xl_drain valid=%h exp=0", bus.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 4'h0;
        bus.in_valid = 1'b1;
        bus.in_sel = 2'd0; bus.in_data = 32'h10; tick();
        bus.in_data = 32'h11; tick();
        bus.in_sel = 2'd2; bus.in_data = 32'h20; tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_count !== 8'h12) begin
            errors++; $display("FAIL mr_fill count=%h exp=12", bus.out_count);
        end
        #2 clrn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 4'h0 || bus.out_count !== 8'h00) begin
            errors++; $display("FAIL mr_async valid=%h count=%h exp 0/00", bus.out_valid, bus.out_count);
        end
        #2 clrn = 1'b1;
        bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'h55;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_count !== 8'h10 || bus.out_data[95:64] !== 32'h55) begin
            errors++; $display("FAIL mr_after valid=%b count=%h lane2=%h exp 0100/10/55",
                               bus.out_valid, bus.out_count, bus.out_data[95:64]);
        end
        bus.out_ready = 4'hf;
        tick();
        bus.out_ready = 4'h0;
        #1;
        checks++;
        if (bus.out_valid !== 4'h0) begin
            errors++; $display("FAIL mr_only_one valid=%h exp=0", bus.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_wraparound();
        test_cross_lane();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
